// File: rtl/frame_write_channel.sv
// Frame write channel: carves one frame into arbiter write bursts, fed from a show-ahead FIFO.
// A burst is issued only once the FIFO already holds every word that burst needs.
module frame_write_channel #(
  parameter int          MEM_DATA_BITS = 64,
  parameter logic [9:0]  BURST_LEN     = 10'd128,
  parameter logic [23:0] FRAME_WORDS   = 24'd518400
) (
  input  logic                     mem_clk,
  input  logic                     rst,
  input  logic                     write_req,
  input  logic [23:0]              write_base_addr,
  output logic                     write_req_ack,
  input  logic [15:0]              fifo_rdusedw,
  output logic                     fifo_rd_en,
  input  logic [MEM_DATA_BITS-1:0] fifo_data,
  output logic                     wr_burst_req,
  output logic [9:0]               wr_burst_len,
  output logic [23:0]              wr_burst_addr,
  input  logic                     wr_burst_data_req,
  output logic [MEM_DATA_BITS-1:0] wr_burst_data,
  input  logic                     wr_burst_finish,
  output logic                     frame_done,
  output logic                     fifo_underflow
);

  // state   | meaning
  // S_IDLE  | waiting for write_req
  // S_ACK   | frame accepted, write_req_ack high
  // S_CHECK | waiting for enough FIFO words for the next burst
  // S_BURST | burst outstanding at the arbiter
  // S_NEXT  | advance counters, end frame or go back to S_CHECK
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACK   = 3'd1,
    S_CHECK = 3'd2,
    S_BURST = 3'd3,
    S_NEXT  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic [23:0] r_base;
  logic [23:0] r_words_left;
  logic [23:0] r_offset;
  logic        r_burst_req;
  logic [9:0]  r_burst_len;
  logic [23:0] r_burst_addr;
  logic        r_req_ack;
  logic        r_frame_done;
  logic        r_underflow;

  logic        w_len_is_max;
  logic [9:0]  w_cur_len;
  logic        w_fifo_ready;
  logic [23:0] w_words_after;
  logic        w_frame_end;

  // Short tail burst: words_left fits in 10 bits whenever it is below BURST_LEN
  assign w_len_is_max  = ({14'd0, BURST_LEN} < r_words_left);
  assign w_cur_len     = w_len_is_max ? BURST_LEN : r_words_left[9:0];
  assign w_fifo_ready  = ({8'd0, fifo_rdusedw} >= {14'd0, w_cur_len});
  assign w_words_after = r_words_left - {14'd0, r_burst_len};
  assign w_frame_end   = (w_words_after == 24'd0);

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (write_req) w_next_state = S_ACK;
      S_ACK:   w_next_state = S_CHECK;
      S_CHECK: if (w_fifo_ready) w_next_state = S_BURST;
      S_BURST: if (wr_burst_finish) w_next_state = S_NEXT;
      S_NEXT:  w_next_state = w_frame_end ? S_IDLE : S_CHECK;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    fifo_rd_en = 1'b0;
    if (r_state == S_BURST && !rst) fifo_rd_en = wr_burst_data_req;
  end

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      r_base       <= 24'd0;
      r_words_left <= 24'd0;
      r_offset     <= 24'd0;
      r_burst_req  <= 1'b0;
      r_burst_len  <= 10'd0;
      r_burst_addr <= 24'd0;
      r_req_ack    <= 1'b0;
      r_frame_done <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_req_ack    <= (r_state == S_IDLE) && write_req;
      r_frame_done <= (r_state == S_NEXT) && w_frame_end;
      if (fifo_rd_en && fifo_rdusedw == 16'd0) r_underflow <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (write_req) begin
            r_base       <= write_base_addr;
            r_words_left <= FRAME_WORDS;
            r_offset     <= 24'd0;
          end
        end
        S_CHECK: begin
          if (w_fifo_ready) begin
            r_burst_len  <= w_cur_len;
            r_burst_addr <= r_base + r_offset;
            r_burst_req  <= 1'b1;
          end
        end
        S_BURST: begin
          if (wr_burst_finish) r_burst_req <= 1'b0;
        end
        S_NEXT: begin
          r_words_left <= w_words_after;
          r_offset     <= r_offset + {14'd0, r_burst_len};
        end
        default: ;
      endcase
    end
  end

  assign write_req_ack  = r_req_ack;
  assign wr_burst_req   = r_burst_req;
  assign wr_burst_len   = r_burst_len;
  assign wr_burst_addr  = r_burst_addr;
  assign wr_burst_data  = fifo_data;
  assign frame_done     = r_frame_done;
  assign fifo_underflow = r_underflow;

endmodule
